// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor: d = a - b - bin, one bit per clock,
//   LSB first, through a single full-subtractor cell and a borrow flip-flop.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled only while idle
//   a      minuend, captured on the accepted start edge
//   b      subtrahend, captured on the accepted start edge
//   bin    borrow-in, captured on the accepted start edge
//   busy   high while bits are being processed
//   done   one-cycle pulse, d/bout valid
//   d      registered difference (held until the next completion)
//   bout   registered borrow-out (1 when a < b + bin, unsigned)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;

    logic             w_diff;
    logic             w_borrow;
    logic             w_last;
    logic [WIDTH-1:0] w_r_next;

    // Full-subtractor cell on the current LSBs.
    assign w_diff   = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    assign w_borrow = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Result shift register with the new bit entering at the MSB; written as
    // shift-then-insert so it stays legal when WIDTH is 1.
    always_comb begin
        w_r_next            = r_r_sh >> 1;
        w_r_next[WIDTH-1]   = w_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_r_sh <= w_r_next;
                    r_br   <= w_borrow;
                    if (w_last) begin
                        // Exit before the counter could wrap.
                        r_cnt   <= '0;
                        r_d     <= w_r_next;
                        r_bout  <= w_borrow;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
//   Expected results come from plain integer arithmetic: {bout,d} = a - b - bin
//   taken modulo 2^WIDTH, with bout set when the integer result is negative.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       s8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;

    logic       s1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, bout1;
    logic [0:0] d1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] prev8 = '0;   // {bout,d} last completed on the 8-bit instance
    logic [8:0] prev1 = '0;   // {bout,d} last completed on the 1-bit instance

    logic [7:0] qa [30];
    logic [7:0] qb [30];
    logic       qbin [30];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {bout, d} with d zero-extended to 8 bits.
    function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic bin);
        int         r;
        logic [7:0] dd;
        if (w == 8) r = int'(a) - int'(b) - int'(bin);
        else        r = int'(a[0]) - int'(b[0]) - int'(bin);
        dd = 8'(r);
        if (w == 1) dd = {7'b0, dd[0]};
        return {(r < 0), dd};
    endfunction

    // Called at a negedge with the selected instance idle; returns at the
    // negedge after the done pulse, when a new start may be presented.
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input string tag);
        logic [8:0] exp, prev, cur;
        logic       cbusy, cdone;
        int         cyc, nbusy;
        exp  = ref_sub(w, a, b, bin);
        prev = (w == 8) ? prev8 : prev1;
        if (w == 8) begin s8 = 1'b1; a8 = a; b8 = b; bin8 = bin; end
        else begin s1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bin; end
        @(negedge clk);
        // Operands are don't-care once accepted.
        s8 = 1'b0; s1 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
        a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
        cyc = 1; nbusy = 0;
        while (cyc < 40) begin
            cdone = (w == 8) ? done8 : done1;
            cbusy = (w == 8) ? busy8 : busy1;
            cur   = (w == 8) ? {bout8, d8} : {bout1, 7'b0, d1};
            if (cdone) break;
            if (cbusy) nbusy++;
            check_eq({tag, "_hold"}, 32'(cur), 32'(prev));
            @(negedge clk);
            cyc++;
        end
        cbusy = (w == 8) ? busy8 : busy1;
        cur   = (w == 8) ? {bout8, d8} : {bout1, 7'b0, d1};
        check_eq({tag, "_latency"}, 32'(cyc), 32'(w + 1));
        check_eq({tag, "_busycnt"}, 32'(nbusy), 32'(w));
        check_eq({tag, "_busy_at_done"}, 32'(cbusy), 32'(0));
        check_eq({tag, "_result"}, 32'(cur), 32'(exp));
        @(negedge clk);
        cdone = (w == 8) ? done8 : done1;
        check_eq({tag, "_done_pulse"}, 32'(cdone), 32'(0));
        if (w == 8) prev8 = exp; else prev1 = exp;
    endtask

    initial begin : main
        logic [8:0] hold, exp;
        int         ndone;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy8), 32'(0));
        check_eq("rst_done", 32'(done8), 32'(0));
        check_eq("rst_d_bout", 32'({bout8, d8}), 32'(0));
        check_eq("rst_w1", 32'({busy1, done1, bout1, d1}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(8, 8'h5A, 8'h3C, 1'b0, "basic");
        check_eq("basic_d_const", 32'({bout8, d8}), 32'(9'h01E));
        do_op(8, 8'h00, 8'h01, 1'b0, "underflow");
        check_eq("underflow_const", 32'({bout8, d8}), 32'(9'h1FF));
        do_op(8, 8'h10, 8'h0F, 1'b1, "bin_zero");
        check_eq("bin_zero_const", 32'({bout8, d8}), 32'(9'h000));
        do_op(8, 8'hFF, 8'hFF, 1'b1, "bin_ff");
        check_eq("bin_ff_const", 32'({bout8, d8}), 32'(9'h1FF));

        // start held high with operands changing every cycle
        hold = prev8;
        for (int t = 0; t < 30; t++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1)); s8 = 1'b1;
            qa[t] = a8; qb[t] = b8; qbin[t] = bin8;
            @(negedge clk);
            if (t % 10 == 8) begin
                exp = ref_sub(8, qa[t-8], qb[t-8], qbin[t-8]);
                check_eq("held_done", 32'(done8), 32'(1));
                check_eq("held_result", 32'({bout8, d8}), 32'(exp));
                hold = exp;
            end else begin
                check_eq("held_nodone", 32'(done8), 32'(0));
                check_eq("held_stable", 32'({bout8, d8}), 32'(hold));
            end
        end
        s8 = 1'b0;
        prev8 = hold;
        @(negedge clk);

        // Asynchronous reset four cycles into SHIFT
        s8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy8), 32'(0));
        check_eq("arst_done", 32'(done8), 32'(0));
        check_eq("arst_d_bout", 32'({bout8, d8}), 32'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check_eq("arst_no_done", 32'(ndone), 32'(0));
        prev8 = '0;
        prev1 = '0;
        do_op(8, 8'h80, 8'h01, 1'b0, "after_rst");
        check_eq("after_rst_const", 32'({bout8, d8}), 32'(9'h07F));

        // Randomised operations
        for (int i = 0; i < 1000; i++)
            do_op(8, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");
        for (int i = 0; i < 1000; i++)
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
